onehot_decoder_pipe: RTL and testbench
======================================

Name: onehot_decoder_pipe

Overview:
- Registered binary-to-one-hot decoder with valid/ready handshakes on both sides. It is the decode end of the priority/binary encoder path.
- Takes an IN_W-bit code and produces an OUT_W-bit one-hot word.
- A 2-entry skid buffer lets downstream stall without dropping codes.
- Flags out-of-range codes and keeps a saturating count of good decodes delivered.

Parameters:
IN_W, 2, width of binary input code (1..8)
OUT_W, 4, width of one-hot output; must satisfy IN_W < OUT_W <= 2**IN_W
CNT_W, 16, width of delivered-decode counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  in_code valid this cycle
in_ready  output  1  block can accept in_code this cycle
in_code  input  IN_W  binary code to decode
out_valid  output  1  out_onehot/out_err valid
out_ready  input  1  downstream accepts output this cycle
out_onehot  output  OUT_W  one-hot decode of the code (bit in_code set)
out_err  output  1  code was >= OUT_W; out_onehot is all-zero
dec_count  output  CNT_W  number of out transfers with out_err=0, saturating

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - in_ready=1, out_valid=0, out_onehot=0, out_err=0, dec_count=0.
  - Skid register is empty.
  - Assertion mid-operation discards all buffered entries immediately. No partial transfer completes.
- Handshake rules:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
  - Once out_valid=1, out_onehot and out_err are held stable until the output transfer.
- Decode, at acceptance time:
  - If in_code < OUT_W: onehot = 1 << in_code, err=0.
  - Else: onehot = 0, err=1.
  - Decoded value is stored with the entry. No combinational path from in_code to outputs.
- Latency: accepted code appears on out_* the next cycle when the buffer was empty or draining.
- in_ready is a register output: in_ready = !skid_full. No combinational path from out_ready to in_ready.
- Buffer state machine (main register M, skid register S):
  - EMPTY (out_valid=0, in_ready=1):
    - Input transfer -> load M, go ONE.
  - ONE (out_valid=1, in_ready=1):
    - in xfer & out xfer -> M <= new, stay ONE.
    - in xfer only -> S <= new, go FULL.
    - out xfer only -> go EMPTY.
    - Neither -> hold.
  - FULL (out_valid=1, in_ready=0):
    - in_valid ignored.
    - out xfer -> M <= S, go ONE.
    - Otherwise hold.
- Ordering: codes emerge in acceptance order. None are dropped or duplicated.
- dec_count:
  - Increments by 1 on each output transfer with out_err=0.
  - No increment on err transfers.
  - Saturates at 2**CNT_W-1, never wraps.
- Simultaneous in and out transfer in FULL is impossible (in_ready=0).

Test Plan:
- Reset then in_code=0,1,2,3 back-to-back, out_ready=1 -> out_onehot 0001,0010,0100,1000 one cycle after each accept; out_err=0; dec_count=4.
- out_ready=0, present codes 1,2,3 -> 1 and 2 accepted; in_ready falls to 0 after second accept; 3 held off. Raise out_ready -> outputs 0010,0100,1000 in order; dec_count=3.
- OUT_W=3, IN_W=2, in_code=3 -> out_onehot=000, out_err=1, dec_count unchanged. Then code 2 -> 100, err=0.
- Assert rst_n=0 asynchronously while FULL with out_ready=0 -> outputs immediately go to reset values. After release: in_ready=1, out_valid=0, dec_count=0.
- CNT_W=2, stream 5 valid codes -> dec_count reads 1,2,3,3,3 (saturates).
- Random in_valid/out_ready toggling over 1000 codes -> scoreboard sees every code decoded once, in order, with out_* stable while stalled.

Source files
------------

// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-one-hot decoder behind a 2-entry skid buffer.
// Codes are decoded on acceptance; the stored word drives the outputs directly.
module onehot_decoder_pipe #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic             out_err,
  output logic [CNT_W-1:0] dec_count
);

  // Valid/ready: a transfer happens on a rising edge where both valid and
  // ready are high; out_onehot/out_err hold steady while out_valid waits.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [OUT_W-1:0] m_onehot, s_onehot, dec_onehot;
  logic             m_err, s_err, dec_err;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt;
  logic             in_xfer, out_xfer;
  logic             load_m_new, load_m_skid, load_s;

  always_comb begin
    dec_onehot = '0;
    for (int i = 0; i < OUT_W; i++) begin
      dec_onehot[i] = (in_code == IN_W'(i));
    end
    dec_err = ~|dec_onehot;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state != EMPTY);
  assign out_onehot = m_onehot;
  assign out_err    = m_err;
  assign dec_count  = cnt;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_nxt   = state;
    load_m_new  = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          load_m_new = 1'b1;
          state_nxt  = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_m_new = 1'b1;
        end else if (in_xfer) begin
          load_s    = 1'b1;
          state_nxt = FULL;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          load_m_skid = 1'b1;
          state_nxt   = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      // Registered so out_ready never reaches in_ready combinationally.
      in_ready_q <= (state_nxt != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_onehot <= '0;
      m_err    <= 1'b0;
      s_onehot <= '0;
      s_err    <= 1'b0;
    end else begin
      if (load_m_new) begin
        m_onehot <= dec_onehot;
        m_err    <= dec_err;
      end else if (load_m_skid) begin
        m_onehot <= s_onehot;
        m_err    <= s_err;
      end
      if (load_s) begin
        s_onehot <= dec_onehot;
        s_err    <= dec_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (out_xfer && !m_err && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Bench for onehot_decoder_pipe: queue-based model on a 2/4/16 instance,
// directed literal checks on both that and a 2/3/2 instance.
module tb_onehot_decoder_pipe;

  localparam int IN_W  = 2;
  localparam int OUT_W = 4;
  localparam int CNT_W = 16;

  logic clk;
  logic rst_n;

  logic             m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_err;
  logic [IN_W-1:0]  m_in_code;
  logic [OUT_W-1:0] m_out_onehot;
  logic [CNT_W-1:0] m_dec_count;

  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err;
  logic [1:0] s_in_code;
  logic [2:0] s_out_onehot;
  logic [1:0] s_dec_count;

  int n_vec = 0;
  int n_err = 0;

  onehot_decoder_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_main (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_code(m_in_code),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_onehot(m_out_onehot), .out_err(m_out_err), .dec_count(m_dec_count)
  );

  onehot_decoder_pipe #(.IN_W(2), .OUT_W(3), .CNT_W(2)) u_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_code(s_in_code),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_onehot(s_out_onehot), .out_err(s_out_err), .dec_count(s_dec_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: a FIFO of decoded words, at most two deep
  logic [OUT_W:0] exp_q[$];
  longint         exp_cnt = 0;
  int             delivered = 0;
  logic [OUT_W:0] prev_word;
  bit             prev_valid = 0;

  function automatic logic [OUT_W:0] ref_dec(input int code);
    if (code < OUT_W) return {1'b0, OUT_W'(1 << code)};
    return {1'b1, {OUT_W{1'b0}}};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt    = 0;
      prev_valid = 0;
    end else begin
      bit do_in, do_out;
      do_in  = m_in_valid && (exp_q.size() < 2);
      do_out = m_out_ready && (exp_q.size() > 0);
      if (do_out) begin
        if (!exp_q[0][OUT_W] && exp_cnt < (longint'(1) << CNT_W) - 1) exp_cnt++;
        void'(exp_q.pop_front());
        delivered++;
      end
      if (do_in) exp_q.push_back(ref_dec(int'(m_in_code)));
    end
  end

  // scoreboard compare on every falling edge out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", m_in_ready, exp_q.size() < 2);
      chk("out_valid", m_out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk("out_onehot", m_out_onehot, exp_q[0][OUT_W-1:0]);
        chk("out_err", m_out_err, exp_q[0][OUT_W]);
      end
      chk("dec_count", m_dec_count, exp_cnt[31:0]);
      if (prev_valid && !m_out_ready)
        chk("stable", {m_out_err, m_out_onehot}, prev_word);
      prev_valid = m_out_valid;
      prev_word  = {m_out_err, m_out_onehot};
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    m_in_valid = 0; m_out_ready = 0; m_in_code = '0;
    s_in_valid = 0; s_out_ready = 0; s_in_code = '0;
    @(negedge clk);
    chk("rst_m_in_ready", m_in_ready, 1);
    chk("rst_m_out_valid", m_out_valid, 0);
    chk("rst_m_onehot", m_out_onehot, 0);
    chk("rst_m_err", m_out_err, 0);
    chk("rst_m_count", m_dec_count, 0);
    chk("rst_s_in_ready", s_in_ready, 1);
    chk("rst_s_out_valid", s_out_valid, 0);
    #1 rst_n = 1'b1;
  endtask

  logic [3:0] lit1[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [1:0] lit_sat[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  int  sent, cycles, d0;
  bit  will_acc;

  initial begin
    rst_n = 1'b1;
    m_in_valid = 0; m_out_ready = 0; m_in_code = '0;
    s_in_valid = 0; s_out_ready = 0; s_in_code = '0;

    // codes 0..3 back to back, downstream always ready
    do_reset();
    m_out_ready = 1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 4) chk("t1_onehot", m_out_onehot, lit1[k-1]);
      if (k == 5) chk("t1_count", m_dec_count, 4);
      #1;
      if (k < 4) begin m_in_valid = 1; m_in_code = 2'(k); end
      else m_in_valid = 0;
    end

    // stall downstream: fill, hold off a third code, then drain in order
    do_reset();
    m_out_ready = 0;
    @(negedge clk); #1 m_in_valid = 1; m_in_code = 2'd1;
    @(negedge clk); chk("t2_ready_one", m_in_ready, 1);
    #1 m_in_code = 2'd2;
    @(negedge clk); chk("t2_ready_full", m_in_ready, 0);
    #1 m_in_code = 2'd3;
    @(negedge clk); chk("t2_hold_ready", m_in_ready, 0);
    chk("t2_hold_onehot", m_out_onehot, 4'b0010);
    #1 m_out_ready = 1;
    @(negedge clk); chk("t2_second", m_out_onehot, 4'b0100);
    chk("t2_ready_back", m_in_ready, 1);
    @(negedge clk); chk("t2_third", m_out_onehot, 4'b1000);
    #1 m_in_valid = 0;
    @(negedge clk); chk("t2_count", m_dec_count, 3);
    chk("t2_empty", m_out_valid, 0);

    // asynchronous reset while FULL and stalled
    #1 m_out_ready = 0; m_in_valid = 1; m_in_code = 2'd0;
    @(negedge clk); #1 m_in_code = 2'd1;
    @(negedge clk); chk("t3_full", m_in_ready, 0);
    #1 m_in_valid = 0;
    #1 rst_n = 0;
    #1;
    chk("t3_rst_valid", m_out_valid, 0);
    chk("t3_rst_ready", m_in_ready, 1);
    chk("t3_rst_count", m_dec_count, 0);
    chk("t3_rst_onehot", m_out_onehot, 0);
    #1 rst_n = 1;
    @(negedge clk);
    chk("t3_post_ready", m_in_ready, 1);
    chk("t3_post_valid", m_out_valid, 0);
    chk("t3_post_count", m_dec_count, 0);

    // random handshakes over 1000 codes
    sent = 0; cycles = 0; d0 = delivered; will_acc = 0;
    while (sent < 1000 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (will_acc) sent++;
      #1;
      if (sent >= 1000) m_in_valid = 0;
      else if (!m_in_valid || will_acc) begin
        m_in_valid = ($urandom_range(0, 3) != 0);
        m_in_code  = 2'($urandom_range(0, 3));
      end
      m_out_ready = ($urandom_range(0, 2) != 0);
      will_acc = m_in_valid && m_in_ready;
    end
    chk("rand_sent", sent, 1000);
    m_in_valid = 0;
    m_out_ready = 1;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    chk("rand_delivered", delivered - d0, 1000);
    chk("rand_drained", m_out_valid, 0);

    // OUT_W=3: out-of-range code, then an in-range one
    do_reset();
    @(negedge clk); #1 s_out_ready = 0; s_in_valid = 1; s_in_code = 2'd3;
    @(negedge clk);
    chk("s_err_onehot", s_out_onehot, 3'b000);
    chk("s_err_flag", s_out_err, 1);
    chk("s_err_valid", s_out_valid, 1);
    chk("s_err_count", s_dec_count, 0);
    #1 s_out_ready = 1; s_in_code = 2'd2;
    @(negedge clk);
    chk("s_ok_onehot", s_out_onehot, 3'b100);
    chk("s_ok_flag", s_out_err, 0);
    chk("s_count_after_err", s_dec_count, 0);
    #1 s_in_valid = 0;
    @(negedge clk);
    chk("s_count_ok", s_dec_count, 1);

    // CNT_W=2 saturation
    do_reset();
    s_out_ready = 1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 2) chk("s_sat", s_dec_count, lit_sat[k-2]);
      #1;
      if (k < 5) begin s_in_valid = 1; s_in_code = 2'(k % 3); end
      else s_in_valid = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
